// File: rtl/rvs_rt_responder_pkg.sv
// Shared types and sizing for the RVS retire responder: write-back payload,
// VCSR snapshot layout and default lane/port/FIFO dimensions.
package rvs_rt_responder_pkg;

    localparam int NUM_RT_UOP       = 4;
    localparam int XRF_WR_PORTS     = 2;
    localparam int XWB_DEPTH        = 8;
    localparam int XLEN             = 32;
    localparam int VCSR_VXSAT_WIDTH = 1;
    localparam int XRF_ADDR_W       = 5;

    typedef struct packed {
        logic [XRF_ADDR_W-1:0] rt_index;
        logic [XLEN-1:0]       rt_data;
    } RT2XRF_t;

    typedef struct packed {
        logic [7:0] vstart;
        logic [8:0] vl;
        logic [1:0] vxrm;
        logic       vxsat;
        logic       vma;
        logic       vta;
        logic [2:0] vsew;
        logic [2:0] vlmul;
    } RVVConfigState;

endpackage

// File: rtl/rvs_rt_responder_if.sv
// Retire write-back channel from the RVV backend (master) to the scalar side (slave).
// Handshake: a lane transfers in any cycle where its valid and ready are both high;
// ready never depends on valid, and valid/payload may change freely when not transferred.
interface rvs_rt_responder_if;
    import rvs_rt_responder_pkg::*;

    RT2XRF_t [NUM_RT_UOP-1:0] rt_xrf_rvv2rvs;
    logic    [NUM_RT_UOP-1:0] rt_xrf_valid_rvv2rvs;
    logic    [NUM_RT_UOP-1:0] rt_xrf_ready_rvs2rvv;

    modport master (
        output rt_xrf_rvv2rvs,
        output rt_xrf_valid_rvv2rvs,
        input  rt_xrf_ready_rvs2rvv
    );

    modport slave (
        input  rt_xrf_rvv2rvs,
        input  rt_xrf_valid_rvv2rvs,
        output rt_xrf_ready_rvs2rvv
    );

endinterface

// File: rtl/rvs_xwb_fifo.sv
// In-order FIFO accepting up to PUSH_W compacted entries and releasing up to POP_W
// entries per cycle; head outputs are plain reads of registered storage.
module rvs_xwb_fifo
    import rvs_rt_responder_pkg::*;
#(
    parameter int DEPTH  = XWB_DEPTH,
    parameter int PUSH_W = NUM_RT_UOP,
    parameter int POP_W  = XRF_WR_PORTS,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH + 1),
    localparam int PCW   = $clog2(PUSH_W + 1),
    localparam int QCW   = $clog2(POP_W + 1)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  RT2XRF_t [PUSH_W-1:0]   push_data,
    input  logic    [PCW-1:0]      push_cnt,
    input  logic    [QCW-1:0]      pop_cnt,
    output RT2XRF_t [POP_W-1:0]    head,
    output logic    [CW-1:0]       count
);

    RT2XRF_t        mem [DEPTH];
    logic [AW-1:0]  wptr;
    logic [AW-1:0]  rptr;
    logic [CW-1:0]  count_q;

    // Storage is not reset: entries are only observable below count_q.
    always_ff @(posedge clk) begin
        for (int k = 0; k < PUSH_W; k++) begin
            if (k < int'(push_cnt)) begin
                mem[wptr + AW'(k)] <= push_data[k];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr    <= '0;
            rptr    <= '0;
            count_q <= '0;
        end else begin
            wptr    <= wptr + AW'(push_cnt);
            rptr    <= rptr + AW'(pop_cnt);
            count_q <= count_q + CW'(push_cnt) - CW'(pop_cnt);
        end
    end

    always_comb begin
        for (int p = 0; p < POP_W; p++) begin
            head[p] = mem[rptr + AW'(p)];
        end
    end

    assign count = count_q;

endmodule

// File: rtl/rvs_rt_responder.sv
// Scalar-side retire responder: buffers RVV x-register write-backs, drains them onto
// the scalar XRF write ports in order, and holds sticky vxsat plus the trap VCSR snapshot.
module rvs_rt_responder
    import rvs_rt_responder_pkg::*;
#(
    parameter int RSP_XWB_DEPTH    = XWB_DEPTH,
    parameter int RSP_XRF_WR_PORTS = XRF_WR_PORTS
) (
    input  logic                                        clk,
    input  logic                                        rst_n,
    rvs_rt_responder_if.slave                           rt_xrf,
    output logic [RSP_XRF_WR_PORTS-1:0]                 xrf_wr_valid,
    output logic [RSP_XRF_WR_PORTS-1:0][XRF_ADDR_W-1:0] xrf_wr_addr,
    output logic [RSP_XRF_WR_PORTS-1:0][XLEN-1:0]       xrf_wr_data,
    input  logic [RSP_XRF_WR_PORTS-1:0]                 xrf_wr_ready,
    input  logic [NUM_RT_UOP-1:0]                       wr_vxsat_valid,
    input  logic [NUM_RT_UOP-1:0][VCSR_VXSAT_WIDTH-1:0] wr_vxsat,
    output logic                                        wr_vxsat_ready,
    input  logic                                        csr_vxsat_we,
    input  logic                                        csr_vxsat_wdata,
    output logic                                        vxsat_q,
    input  logic                                        vcsr_valid,
    input  RVVConfigState                               vector_csr,
    output logic                                        vcsr_ready,
    output logic                                        trap_vcsr_valid,
    output RVVConfigState                               trap_vcsr,
    input  logic                                        trap_ack,
    output logic                                        xwb_busy
);

    localparam int CW  = $clog2(RSP_XWB_DEPTH + 1);
    localparam int PCW = $clog2(NUM_RT_UOP + 1);
    localparam int QCW = $clog2(RSP_XRF_WR_PORTS + 1);
    localparam int LW  = $clog2(NUM_RT_UOP);

    logic [CW-1:0]                          count;
    logic [CW-1:0]                          free;
    logic [NUM_RT_UOP-1:0]                  lane_ready;
    logic [NUM_RT_UOP-1:0]                  lane_acc;
    RT2XRF_t [NUM_RT_UOP-1:0]               push_data;
    logic [PCW-1:0]                         push_cnt;
    logic [QCW-1:0]                         pop_cnt;
    RT2XRF_t [RSP_XRF_WR_PORTS-1:0]         head;
    logic                                   pop_run;
    logic                                   sat_any;

    // Credit only the registered occupancy; pops this cycle free space next cycle.
    assign free = CW'(RSP_XWB_DEPTH) - count;

    always_comb begin
        for (int i = 0; i < NUM_RT_UOP; i++) begin
            lane_ready[i] = rst_n && (free >= CW'(i + 1));
        end
    end

    assign rt_xrf.rt_xrf_ready_rvs2rvv = lane_ready;
    assign lane_acc = rt_xrf.rt_xrf_valid_rvv2rvs & lane_ready;

    // Pack accepted lanes densely in ascending lane order.
    always_comb begin
        push_data = '0;
        push_cnt  = '0;
        for (int i = 0; i < NUM_RT_UOP; i++) begin
            if (lane_acc[i]) begin
                push_data[push_cnt[LW-1:0]] = rt_xrf.rt_xrf_rvv2rvs[i];
                push_cnt = push_cnt + PCW'(1);
            end
        end
    end

    always_comb begin
        for (int p = 0; p < RSP_XRF_WR_PORTS; p++) begin
            xrf_wr_valid[p] = (count > CW'(p));
            xrf_wr_addr[p]  = head[p].rt_index;
            xrf_wr_data[p]  = head[p].rt_data;
        end
    end

    // Only the leading run of accepted ports retires, so order is never broken.
    always_comb begin
        pop_cnt = '0;
        pop_run = 1'b1;
        for (int p = 0; p < RSP_XRF_WR_PORTS; p++) begin
            if (pop_run && xrf_wr_valid[p] && xrf_wr_ready[p]) begin
                pop_cnt = pop_cnt + QCW'(1);
            end else begin
                pop_run = 1'b0;
            end
        end
    end

    rvs_xwb_fifo #(
        .DEPTH  (RSP_XWB_DEPTH),
        .PUSH_W (NUM_RT_UOP),
        .POP_W  (RSP_XRF_WR_PORTS)
    ) u_xwb_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push_data (push_data),
        .push_cnt  (push_cnt),
        .pop_cnt   (pop_cnt),
        .head      (head),
        .count     (count)
    );

    assign xwb_busy = (count != '0);

    always_comb begin
        sat_any = 1'b0;
        for (int i = 0; i < NUM_RT_UOP; i++) begin
            sat_any = sat_any | (wr_vxsat_valid[i] & wr_vxsat[i][0]);
        end
    end

    // A scalar CSR write wins over and blocks vector saturation updates.
    assign wr_vxsat_ready = rst_n && !csr_vxsat_we;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vxsat_q <= 1'b0;
        end else if (csr_vxsat_we) begin
            vxsat_q <= csr_vxsat_wdata;
        end else if (sat_any) begin
            vxsat_q <= 1'b1;
        end
    end

    assign vcsr_ready = rst_n && (!trap_vcsr_valid || trap_ack);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            trap_vcsr_valid <= 1'b0;
            trap_vcsr       <= '0;
        end else if (vcsr_valid && vcsr_ready) begin
            trap_vcsr_valid <= 1'b1;
            trap_vcsr       <= vector_csr;
        end else if (trap_ack) begin
            trap_vcsr_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rvs_rt_responder.sv
// Directed bench for rvs_rt_responder: drain order, full/stall, sparse lanes,
// port ordering, sticky vxsat and the trap snapshot slot.
module tb_rvs_rt_responder;
    import rvs_rt_responder_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    logic [XRF_WR_PORTS-1:0]                 xrf_wr_valid;
    logic [XRF_WR_PORTS-1:0][XRF_ADDR_W-1:0] xrf_wr_addr;
    logic [XRF_WR_PORTS-1:0][XLEN-1:0]       xrf_wr_data;
    logic [XRF_WR_PORTS-1:0]                 xrf_wr_ready;
    logic [NUM_RT_UOP-1:0]                   wr_vxsat_valid;
    logic [NUM_RT_UOP-1:0][VCSR_VXSAT_WIDTH-1:0] wr_vxsat;
    logic                                    wr_vxsat_ready;
    logic                                    csr_vxsat_we;
    logic                                    csr_vxsat_wdata;
    logic                                    vxsat_q;
    logic                                    vcsr_valid;
    RVVConfigState                           vector_csr;
    logic                                    vcsr_ready;
    logic                                    trap_vcsr_valid;
    RVVConfigState                           trap_vcsr;
    logic                                    trap_ack;
    logic                                    xwb_busy;

    int n_pass  = 0;
    int n_total = 0;

    rvs_rt_responder_if rt_if ();

    rvs_rt_responder dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .rt_xrf          (rt_if.slave),
        .xrf_wr_valid    (xrf_wr_valid),
        .xrf_wr_addr     (xrf_wr_addr),
        .xrf_wr_data     (xrf_wr_data),
        .xrf_wr_ready    (xrf_wr_ready),
        .wr_vxsat_valid  (wr_vxsat_valid),
        .wr_vxsat        (wr_vxsat),
        .wr_vxsat_ready  (wr_vxsat_ready),
        .csr_vxsat_we    (csr_vxsat_we),
        .csr_vxsat_wdata (csr_vxsat_wdata),
        .vxsat_q         (vxsat_q),
        .vcsr_valid      (vcsr_valid),
        .vector_csr      (vector_csr),
        .vcsr_ready      (vcsr_ready),
        .trap_vcsr_valid (trap_vcsr_valid),
        .trap_vcsr       (trap_vcsr),
        .trap_ack        (trap_ack),
        .xwb_busy        (xwb_busy)
    );

    // clock/reset block
    always #5 clk = ~clk;

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic set_lane(input int lane, input int idx, input int data);
        rt_if.rt_xrf_rvv2rvs[lane].rt_index = XRF_ADDR_W'(idx);
        rt_if.rt_xrf_rvv2rvs[lane].rt_data  = XLEN'(data);
    endtask

    task automatic idle_inputs();
        rt_if.rt_xrf_rvv2rvs       = '0;
        rt_if.rt_xrf_valid_rvv2rvs = '0;
        xrf_wr_ready               = '0;
        wr_vxsat_valid             = '0;
        wr_vxsat                   = '0;
        csr_vxsat_we               = 1'b0;
        csr_vxsat_wdata            = 1'b0;
        vcsr_valid                 = 1'b0;
        vector_csr                 = '0;
        trap_ack                   = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        rt_if.rt_xrf_valid_rvv2rvs = 4'b1111;
        tick();
        tick();
        n_total++;
        if (rt_if.rt_xrf_ready_rvs2rvv !== 4'b0000)
            $display("FAIL reset_rt_ready got %b want 0000", rt_if.rt_xrf_ready_rvs2rvv);
        else n_pass++;
        n_total++;
        if ({xrf_wr_valid, xwb_busy, vxsat_q, trap_vcsr_valid, wr_vxsat_ready, vcsr_ready} !== 7'b0)
            $display("FAIL reset_outputs got %b want 0000000",
                     {xrf_wr_valid, xwb_busy, vxsat_q, trap_vcsr_valid, wr_vxsat_ready, vcsr_ready});
        else n_pass++;
        n_total++;
        if (trap_vcsr !== '0) $display("FAIL reset_trap_vcsr got %h want 0", trap_vcsr);
        else n_pass++;
        rt_if.rt_xrf_valid_rvv2rvs = '0;
        rst_n = 1'b1;
        tick();
        // reset while entries are buffered discards them
        for (int i = 0; i < 4; i++) set_lane(i, 20 + i, 32'hDEAD0000 + i);
        rt_if.rt_xrf_valid_rvv2rvs = 4'b1111;
        tick();
        rt_if.rt_xrf_valid_rvv2rvs = '0;
        n_total++;
        if (xwb_busy !== 1'b1) $display("FAIL middrain_busy got %b want 1", xwb_busy);
        else n_pass++;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        settle();
        n_total++;
        if ({xwb_busy, xrf_wr_valid} !== 3'b000)
            $display("FAIL middrain_flush got %b want 000", {xwb_busy, xrf_wr_valid});
        else n_pass++;
    endtask

    task automatic test_drain();
        for (int i = 0; i < 4; i++) set_lane(i, i + 1, 32'hA1 + i);
        rt_if.rt_xrf_valid_rvv2rvs = 4'b1111;
        xrf_wr_ready = 2'b11;
        settle();
        n_total++;
        if (rt_if.rt_xrf_ready_rvs2rvv !== 4'b1111)
            $display("FAIL drain_ready got %b want 1111", rt_if.rt_xrf_ready_rvs2rvv);
        else n_pass++;
        tick();
        rt_if.rt_xrf_valid_rvv2rvs = '0;
        settle();
        n_total++;
        if ({xrf_wr_valid, xrf_wr_addr[0], xrf_wr_data[0], xrf_wr_addr[1], xrf_wr_data[1]}
            !== {2'b11, 5'd1, 32'hA1, 5'd2, 32'hA2})
            $display("FAIL drain_cyc1 got v=%b x%0d/%h x%0d/%h want v=11 x1/a1 x2/a2",
                     xrf_wr_valid, xrf_wr_addr[0], xrf_wr_data[0], xrf_wr_addr[1], xrf_wr_data[1]);
        else n_pass++;
        tick();
        n_total++;
        if ({xrf_wr_valid, xrf_wr_addr[0], xrf_wr_data[0], xrf_wr_addr[1], xrf_wr_data[1]}
            !== {2'b11, 5'd3, 32'hA3, 5'd4, 32'hA4})
            $display("FAIL drain_cyc2 got v=%b x%0d/%h x%0d/%h want v=11 x3/a3 x4/a4",
                     xrf_wr_valid, xrf_wr_addr[0], xrf_wr_data[0], xrf_wr_addr[1], xrf_wr_data[1]);
        else n_pass++;
        tick();
        n_total++;
        if ({xwb_busy, xrf_wr_valid} !== 3'b000)
            $display("FAIL drain_done got %b want 000", {xwb_busy, xrf_wr_valid});
        else n_pass++;
        xrf_wr_ready = '0;
    endtask

    task automatic test_fill();
        xrf_wr_ready = 2'b00;
        for (int i = 0; i < 4; i++) set_lane(i, 8 + i, 32'hB0 + i);
        rt_if.rt_xrf_valid_rvv2rvs = 4'b1111;
        tick();
        for (int i = 0; i < 4; i++) set_lane(i, 12 + i, 32'hB4 + i);
        settle();
        n_total++;
        if (rt_if.rt_xrf_ready_rvs2rvv !== 4'b1111)
            $display("FAIL fill_half_ready got %b want 1111", rt_if.rt_xrf_ready_rvs2rvv);
        else n_pass++;
        tick();
        for (int i = 0; i < 4; i++) set_lane(i, 24 + i, 32'hEE);
        rt_if.rt_xrf_valid_rvv2rvs = 4'b0111;
        settle();
        n_total++;
        if (rt_if.rt_xrf_ready_rvs2rvv !== 4'b0000)
            $display("FAIL fill_full_ready got %b want 0000", rt_if.rt_xrf_ready_rvs2rvv);
        else n_pass++;
        tick();
        rt_if.rt_xrf_valid_rvv2rvs = '0;
        xrf_wr_ready = 2'b01;
        settle();
        n_total++;
        if ({rt_if.rt_xrf_ready_rvs2rvv, xrf_wr_valid, xrf_wr_addr[0]} !== {4'b0000, 2'b11, 5'd8})
            $display("FAIL fill_held got rdy=%b v=%b x%0d want rdy=0000 v=11 x8",
                     rt_if.rt_xrf_ready_rvs2rvv, xrf_wr_valid, xrf_wr_addr[0]);
        else n_pass++;
        tick();
        n_total++;
        if (rt_if.rt_xrf_ready_rvs2rvv !== 4'b0001)
            $display("FAIL fill_ready_rise got %b want 0001", rt_if.rt_xrf_ready_rvs2rvv);
        else n_pass++;
        for (int k = 1; k < 8; k++) begin
            n_total++;
            if ({xrf_wr_addr[0], xrf_wr_data[0]} !== {5'(8 + k), 32'(32'hB0 + k)})
                $display("FAIL fill_pop%0d got x%0d/%h want x%0d/%h",
                         k, xrf_wr_addr[0], xrf_wr_data[0], 8 + k, 32'hB0 + k);
            else n_pass++;
            tick();
        end
        n_total++;
        if (xwb_busy !== 1'b0) $display("FAIL fill_empty got busy=%b want 0", xwb_busy);
        else n_pass++;
        xrf_wr_ready = '0;
    endtask

    task automatic test_sparse();
        set_lane(0, 30, 32'h30);
        set_lane(1, 5, 32'h55);
        set_lane(2, 31, 32'h31);
        set_lane(3, 7, 32'h77);
        rt_if.rt_xrf_valid_rvv2rvs = 4'b1010;
        xrf_wr_ready = 2'b00;
        tick();
        rt_if.rt_xrf_valid_rvv2rvs = '0;
        settle();
        n_total++;
        if ({xrf_wr_valid, xrf_wr_addr[0], xrf_wr_data[0], xrf_wr_addr[1], xrf_wr_data[1]}
            !== {2'b11, 5'd5, 32'h55, 5'd7, 32'h77})
            $display("FAIL sparse_order got v=%b x%0d/%h x%0d/%h want v=11 x5/55 x7/77",
                     xrf_wr_valid, xrf_wr_addr[0], xrf_wr_data[0], xrf_wr_addr[1], xrf_wr_data[1]);
        else n_pass++;
    endtask

    task automatic test_port_order();
        xrf_wr_ready = 2'b10;
        tick();
        n_total++;
        if ({xrf_wr_valid, xrf_wr_addr[0], xrf_wr_addr[1]} !== {2'b11, 5'd5, 5'd7})
            $display("FAIL order_stall got v=%b x%0d x%0d want v=11 x5 x7",
                     xrf_wr_valid, xrf_wr_addr[0], xrf_wr_addr[1]);
        else n_pass++;
        xrf_wr_ready = 2'b11;
        tick();
        n_total++;
        if ({xwb_busy, xrf_wr_valid} !== 3'b000)
            $display("FAIL order_release got %b want 000", {xwb_busy, xrf_wr_valid});
        else n_pass++;
        xrf_wr_ready = '0;
    endtask

    task automatic test_vxsat();
        wr_vxsat_valid = 4'b1101;
        wr_vxsat       = 4'b0101;
        settle();
        n_total++;
        if ({wr_vxsat_ready, vxsat_q} !== 2'b10)
            $display("FAIL vxsat_pre got %b want 10", {wr_vxsat_ready, vxsat_q});
        else n_pass++;
        tick();
        wr_vxsat_valid = '0;
        wr_vxsat       = '0;
        n_total++;
        if (vxsat_q !== 1'b1) $display("FAIL vxsat_set got %b want 1", vxsat_q);
        else n_pass++;
        tick();
        n_total++;
        if (vxsat_q !== 1'b1) $display("FAIL vxsat_sticky got %b want 1", vxsat_q);
        else n_pass++;
        csr_vxsat_we    = 1'b1;
        csr_vxsat_wdata = 1'b0;
        wr_vxsat_valid  = 4'b0001;
        wr_vxsat        = 4'b0001;
        settle();
        n_total++;
        if (wr_vxsat_ready !== 1'b0) $display("FAIL vxsat_csr_ready got %b want 0", wr_vxsat_ready);
        else n_pass++;
        tick();
        csr_vxsat_we   = 1'b0;
        wr_vxsat_valid = '0;
        wr_vxsat       = '0;
        n_total++;
        if (vxsat_q !== 1'b0) $display("FAIL vxsat_csr_clear got %b want 0", vxsat_q);
        else n_pass++;
        // a valid update carrying a zero flag leaves vxsat clear
        wr_vxsat_valid = 4'b1111;
        tick();
        wr_vxsat_valid = '0;
        n_total++;
        if (vxsat_q !== 1'b0) $display("FAIL vxsat_zero_flag got %b want 0", vxsat_q);
        else n_pass++;
    endtask

    task automatic test_snapshot();
        vector_csr    = '0;
        vector_csr.vl = 9'd16;
        vector_csr.vsew = 3'd2;
        vcsr_valid    = 1'b1;
        settle();
        n_total++;
        if (vcsr_ready !== 1'b1) $display("FAIL snap_ready0 got %b want 1", vcsr_ready);
        else n_pass++;
        tick();
        vcsr_valid = 1'b0;
        settle();
        n_total++;
        if ({trap_vcsr_valid, vcsr_ready, trap_vcsr.vl, trap_vcsr.vsew} !== {2'b10, 9'd16, 3'd2})
            $display("FAIL snap_held got v=%b rdy=%b vl=%0d sew=%0d want v=1 rdy=0 vl=16 sew=2",
                     trap_vcsr_valid, vcsr_ready, trap_vcsr.vl, trap_vcsr.vsew);
        else n_pass++;
        vector_csr.vl = 9'd8;
        vcsr_valid    = 1'b1;
        trap_ack      = 1'b1;
        settle();
        n_total++;
        if (vcsr_ready !== 1'b1) $display("FAIL snap_ack_ready got %b want 1", vcsr_ready);
        else n_pass++;
        tick();
        vcsr_valid = 1'b0;
        trap_ack   = 1'b0;
        settle();
        n_total++;
        if ({trap_vcsr_valid, trap_vcsr.vl} !== {1'b1, 9'd8})
            $display("FAIL snap_replace got v=%b vl=%0d want v=1 vl=8", trap_vcsr_valid, trap_vcsr.vl);
        else n_pass++;
        trap_ack = 1'b1;
        tick();
        trap_ack = 1'b0;
        settle();
        n_total++;
        if ({trap_vcsr_valid, vcsr_ready} !== 2'b01)
            $display("FAIL snap_ack got v=%b rdy=%b want v=0 rdy=1", trap_vcsr_valid, vcsr_ready);
        else n_pass++;
    endtask

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        test_reset();
        test_drain();
        test_fill();
        test_sparse();
        test_port_order();
        test_vxsat();
        test_snapshot();
        // final report
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
